// File: rtl/mrv1_pkg.sv
// mrv1_pkg: writeback request type shared by the ALU, LSU and writeback stages
package mrv1_pkg;
  localparam int MRV1_DATA_W    = 32;
  localparam int MRV1_TID_W     = 3;
  localparam int MRV1_RF_ADDR_W = 5;
  typedef struct packed {
    logic [MRV1_TID_W-1:0]     tid;
    logic [MRV1_RF_ADDR_W-1:0] rd_addr;
    logic [MRV1_DATA_W-1:0]    data;
  } wb_req_t;
endpackage

// File: rtl/mrv1_wb_fifo.sv
// mrv1_wb_fifo: synchronous FIFO of writeback requests; pointers wrap naturally (power-of-2 depth)
module mrv1_wb_fifo
  import mrv1_pkg::*;
#(
  parameter int DEPTH_P = 4,
  localparam int PW = $clog2(DEPTH_P),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_v_i,
  input  wb_req_t       push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output wb_req_t       head_o,
  output logic [CW-1:0] count_o
);
  wb_req_t mem_q [DEPTH_P];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  assign full_o  = count_q == CW'(DEPTH_P);
  assign empty_o = count_q == '0;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign push    = push_v_i && !full_o;
  assign pop     = pop_i && !empty_o;
  // next pointers/count; a simultaneous push and pop leaves count unchanged
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage write; no reset needed since entries are only read when valid
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/mrv1_wb_arb.sv
// mrv1_wb_arb: RF writeback arbiter, ALU priority over buffered LSU results; MRV1_WB_LSU_BYPASS_EN enables empty-FIFO LSU bypass
module mrv1_wb_arb
  import mrv1_pkg::*;
#(
  parameter int DATA_WIDTH_P     = MRV1_DATA_W,
  parameter int NUM_TW_P         = 8,
  parameter int rf_addr_width_p  = MRV1_RF_ADDR_W,
  parameter int LSU_FIFO_DEPTH_P = 4,
  localparam int tid_width_lp    = $clog2(NUM_TW_P)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alu_v_i,
  input  logic [tid_width_lp-1:0]    alu_tid_i,
  input  logic [rf_addr_width_p-1:0] alu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    alu_data_i,
  input  logic                       lsu_v_i,
  output logic                       lsu_ready_o,
  input  logic [tid_width_lp-1:0]    lsu_tid_i,
  input  logic [rf_addr_width_p-1:0] lsu_rd_addr_i,
  input  logic [DATA_WIDTH_P-1:0]    lsu_data_i,
  output logic [tid_width_lp-1:0]    rd_tid_o,
  output logic                       rd_w_en_o,
  output logic [rf_addr_width_p-1:0] rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]    rd_data_o,
  output logic                       wb_done_v_o,
  output logic [tid_width_lp-1:0]    wb_done_tid_o
);
  localparam int CW = $clog2(LSU_FIFO_DEPTH_P) + 1;
  wb_req_t alu_req, lsu_req, head, sel_d, out_q;
  logic fifo_full, fifo_empty, lsu_fire, bypass, push, pop, sel_v_d;
  logic rd_w_en_q, done_v_q;
  logic [CW-1:0] fifo_count;
  assign alu_req     = {alu_tid_i, alu_rd_addr_i, alu_data_i};
  assign lsu_req     = {lsu_tid_i, lsu_rd_addr_i, lsu_data_i};
  assign lsu_ready_o = !rst_i && !fifo_full;
  assign lsu_fire    = lsu_v_i && lsu_ready_o;
`ifdef MRV1_WB_LSU_BYPASS_EN
  assign bypass = lsu_fire && !alu_v_i && fifo_count == '0;
`else
  assign bypass = 1'b0;
`endif
  assign push = lsu_fire && !bypass;
  assign pop  = !alu_v_i && !fifo_empty;
  mrv1_wb_fifo #(.DEPTH_P(LSU_FIFO_DEPTH_P)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_v_i   (push),
    .push_data_i(lsu_req),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head),
    .count_o    (fifo_count)
  );
  // ALU first, then FIFO head, then (bypass builds only) the live LSU result
  always_comb begin
    sel_v_d = alu_v_i || !fifo_empty || bypass;
    sel_d   = alu_v_i ? alu_req : !fifo_empty ? head : lsu_req;
  end
  // output registers; x0 writes are suppressed but still retire, payload holds when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_w_en_q <= 1'b0;
      done_v_q  <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_w_en_q <= sel_v_d && sel_d.rd_addr != '0;
      done_v_q  <= sel_v_d;
      if (sel_v_d) out_q <= sel_d;
    end
  end
  assign rd_w_en_o     = rd_w_en_q;
  assign wb_done_v_o   = done_v_q;
  assign rd_tid_o      = out_q.tid;
  assign rd_addr_o     = out_q.rd_addr;
  assign rd_data_o     = out_q.data;
  assign wb_done_tid_o = out_q.tid;
endmodule

// File: tb/tb_mrv1_wb_arb.sv
// tb_mrv1_wb_arb: directed scoreboard bench for mrv1_wb_arb (honours MRV1_WB_LSU_BYPASS_EN)
module tb_mrv1_wb_arb;
`ifdef MRV1_WB_LSU_BYPASS_EN
  localparam int LSU_LAT = 1;
`else
  localparam int LSU_LAT = 2;
`endif
  typedef struct packed {
    int          cyc;
    logic [2:0]  tid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
  } exp_t;
  logic clk = 1'b0, rst_i = 1'b1;
  logic alu_v_i = 1'b0, lsu_v_i = 1'b0;
  logic [2:0] alu_tid_i = '0, lsu_tid_i = '0;
  logic [4:0] alu_rd_addr_i = '0, lsu_rd_addr_i = '0;
  logic [31:0] alu_data_i = '0, lsu_data_i = '0;
  logic lsu_ready_o, rd_w_en_o, wb_done_v_o;
  logic [2:0] rd_tid_o, wb_done_tid_o;
  logic [4:0] rd_addr_o;
  logic [31:0] rd_data_o;
  int cyc = 0, checks = 0, errors = 0, idx;
  exp_t sb[$];
  mrv1_wb_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .alu_v_i(alu_v_i), .alu_tid_i(alu_tid_i), .alu_rd_addr_i(alu_rd_addr_i), .alu_data_i(alu_data_i),
    .lsu_v_i(lsu_v_i), .lsu_ready_o(lsu_ready_o), .lsu_tid_i(lsu_tid_i), .lsu_rd_addr_i(lsu_rd_addr_i),
    .lsu_data_i(lsu_data_i), .rd_tid_o(rd_tid_o), .rd_w_en_o(rd_w_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .wb_done_v_o(wb_done_v_o), .wb_done_tid_o(wb_done_tid_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every retired result must match the scoreboard entry due this cycle
  always @(negedge clk) begin
    if (wb_done_v_o || rd_w_en_o) begin
      idx = -1;
      foreach (sb[i]) if (sb[i].cyc == cyc) idx = i;
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL wb_unexpected cyc=%0d got tid=%0d rd=%0d data=%h wen=%b done=%b required no output",
                 cyc, rd_tid_o, rd_addr_o, rd_data_o, rd_w_en_o, wb_done_v_o);
      end else begin
        if ({rd_tid_o, wb_done_tid_o, rd_addr_o, rd_data_o, rd_w_en_o, wb_done_v_o} !==
            {sb[idx].tid, sb[idx].tid, sb[idx].rd, sb[idx].data, sb[idx].wen, 1'b1}) begin
          errors++;
          $display("FAIL wb_result cyc=%0d got tid=%0d/%0d rd=%0d data=%h wen=%b done=%b required tid=%0d rd=%0d data=%h wen=%b done=1",
                   cyc, rd_tid_o, wb_done_tid_o, rd_addr_o, rd_data_o, rd_w_en_o, wb_done_v_o,
                   sb[idx].tid, sb[idx].rd, sb[idx].data, sb[idx].wen);
        end
        sb.delete(idx);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h required %h", name, cyc, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    alu_v_i = 1'b0;
    lsu_v_i = 1'b0;
  endtask
  // ALU busy for na cycles while the LSU offers nl results; rdy[k] is the expected ready in cycle k
  task automatic burst(input int na, input int nl, input logic [7:0] rdy, input int ncyc, input bit exp_lsu);
    int e = cyc;
    int pushed = 0;
    for (int k = 0; k < ncyc; k++) begin
      alu_v_i = k < na;
      alu_tid_i = 3'(k);
      alu_rd_addr_i = 5'(10 + k);
      alu_data_i = 32'hA000 + k;
      if (k < na) sb.push_back('{e + 1 + k, 3'(k), 5'(10 + k), 32'hA000 + k, 1'b1});
      lsu_v_i = pushed < nl;
      lsu_tid_i = 3'(pushed + 4);
      lsu_rd_addr_i = 5'(20 + pushed);
      lsu_data_i = 32'hB000 + pushed;
      if (lsu_v_i) begin
        chk($sformatf("lsu_ready_k%0d", k), {31'b0, lsu_ready_o}, {31'b0, rdy[k]});
        if (lsu_ready_o) begin
          if (exp_lsu) sb.push_back('{e + na + 1 + pushed, 3'(pushed + 4), 5'(20 + pushed), 32'hB000 + pushed, 1'b1});
          pushed++;
        end
      end
      step();
    end
    clear();
  endtask
  initial begin
    step();
    chk("ready_in_reset", {31'b0, lsu_ready_o}, 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    chk("reset_w_en", {31'b0, rd_w_en_o}, 32'd0);
    chk("reset_done", {31'b0, wb_done_v_o}, 32'd0);
    chk("reset_data", rd_data_o, 32'd0);
    chk("reset_tid_addr", {24'b0, rd_tid_o, rd_addr_o}, 32'd0);
    chk("reset_ready", {31'b0, lsu_ready_o}, 32'd1);
    // ALU only, then an idle cycle that must hold the payload
    alu_v_i = 1'b1; alu_tid_i = 3'd3; alu_rd_addr_i = 5'd7; alu_data_i = 32'hDEADBEEF;
    sb.push_back('{cyc + 1, 3'd3, 5'd7, 32'hDEADBEEF, 1'b1});
    step();
    clear();
    step();
    chk("idle_w_en", {31'b0, rd_w_en_o}, 32'd0);
    chk("idle_hold_data", rd_data_o, 32'hDEADBEEF);
    chk("idle_hold_addr", {27'b0, rd_addr_o}, 32'd7);
    // LSU only
    lsu_v_i = 1'b1; lsu_tid_i = 3'd1; lsu_rd_addr_i = 5'd2; lsu_data_i = 32'h55;
    chk("lsu_only_ready", {31'b0, lsu_ready_o}, 32'd1);
    sb.push_back('{cyc + LSU_LAT, 3'd1, 5'd2, 32'h55, 1'b1});
    step();
    clear();
    repeat (4) step();
    // contention: 6 ALU cycles against 5 LSU results
    burst(6, 5, 8'b1000_1111, 8, 1'b1);
    repeat (8) step();
    // x0 destination: retires without a write
    alu_v_i = 1'b1; alu_tid_i = 3'd5; alu_rd_addr_i = 5'd0; alu_data_i = 32'h1234;
    sb.push_back('{cyc + 1, 3'd5, 5'd0, 32'h1234, 1'b0});
    step();
    clear();
    repeat (3) step();
    // full FIFO with a pop in the same cycle still refuses the push
    burst(4, 5, 8'b0010_1111, 6, 1'b1);
    repeat (8) step();
    // reset with 3 LSU entries buffered
    burst(3, 3, 8'b0000_0111, 3, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("mid_reset_ready", {31'b0, lsu_ready_o}, 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    chk("post_reset_ready", {31'b0, lsu_ready_o}, 32'd1);
    chk("post_reset_w_en", {31'b0, rd_w_en_o}, 32'd0);
    chk("post_reset_done", {31'b0, wb_done_v_o}, 32'd0);
    repeat (6) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d outstanding results required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
